// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan code decoder: Scan Code Set 2 prefix bytes,
// keyboard status-byte classification, decoder FSM states and the key event record.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Bytes that follow E1 in the Pause sequence (E1 14 77 E1 F0 14 F0 77).
  localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StSkip
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Keyboard replies (BAT ok, ACK, echo, resend, buffer errors) that carry no key.
  function automatic logic ps2_is_status(input logic [7:0] b);
    logic res;
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: res = 1'b1;
      default:                                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous show-ahead FIFO for decoded key events.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i, wdata_i     write request and data; accepted if not full or popping
//   pop_i               read request; ignored when empty
//   rdata_o             head entry, valid while empty_o is low
//   full_o, empty_o     occupancy flags
module ps2_event_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Extra MSB distinguishes full from empty when the address bits match.
  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    do_push = push_i & (~full_o | do_pop);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds the raw PS/2 Scan Code Set 2 byte stream into one event per key
// {ext, brk, code}, drops the Pause sequence and status bytes, and queues events
// for a valid/ready consumer.
// Ports:
//   app_clk, app_arst_n          clock, asynchronous active-low reset
//   byte_ena, byte_in            received byte strobe and value
//   key_valid, key_ready         event handshake
//   key_code, key_ext, key_break head event fields
//   overflow, overflow_clr       sticky drop flag and its synchronous clear
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       app_clk,
  input  logic       app_arst_n,
  input  logic       byte_ena,
  input  logic [7:0] byte_in,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]    skip_q, skip_d;
  logic          overflow_q, overflow_d;
  logic          push;
  ps2_event_t    push_evt, head;
  logic          fifo_full, fifo_empty;
  logic          timeout;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    push     = 1'b0;
    push_evt = '{ext: 1'b0, brk: 1'b0, code: byte_in};

    // Idle-time counter: cleared by any byte, saturates at the timeout value.
    if (byte_ena)           cnt_d = '0;
    else if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;

    timeout = (state_q != StIdle) && !byte_ena && (cnt_q == CntMax);

    if (byte_ena) begin
      unique case (state_q)
        StIdle: begin
          if (byte_in == PS2_EXT) begin
            state_d = StExt;
          end else if (byte_in == PS2_BRK) begin
            state_d = StBrk;
          end else if (byte_in == PS2_PAUSE) begin
            state_d = StSkip;
            skip_d  = PS2_PAUSE_TAIL;
          end else if (!ps2_is_status(byte_in)) begin
            push = 1'b1;
          end
        end
        StExt: begin
          if (byte_in == PS2_BRK) begin
            state_d = StExtBrk;
          end else if (byte_in != PS2_EXT) begin
            push         = 1'b1;
            push_evt.ext = 1'b1;
            state_d      = StIdle;
          end
        end
        StBrk: begin
          if (byte_in != PS2_BRK) begin
            push         = 1'b1;
            push_evt.brk = 1'b1;
            state_d      = StIdle;
          end
        end
        StExtBrk: begin
          if (byte_in != PS2_BRK) begin
            push         = 1'b1;
            push_evt.ext = 1'b1;
            push_evt.brk = 1'b1;
            state_d      = StIdle;
          end
        end
        StSkip: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (timeout) begin
      state_d = StIdle;
      skip_d  = '0;
    end

    // A pop frees a slot in the same cycle, so only an un-popped push at full drops.
    overflow_d = (push & fifo_full & ~key_ready) | (overflow_q & ~overflow_clr);
  end

  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      skip_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      skip_q     <= skip_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .Width($bits(ps2_event_t)),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (app_clk),
    .rst_ni (app_arst_n),
    .push_i (push),
    .wdata_i(push_evt),
    .pop_i  (key_ready),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign key_valid = ~fifo_empty;
  assign key_code  = head.code;
  assign key_ext   = head.ext;
  assign key_break = head.brk;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

  localparam int unsigned Depth = 4;
  localparam int unsigned To    = 16;

  logic       app_clk = 1'b0;
  logic       app_arst_n;
  logic       byte_ena;
  logic [7:0] byte_in;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       overflow;
  logic       overflow_clr;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    string       name;
    int          n;
    logic [31:0] bytes;   // byte i in bits [8*i +: 8]
    logic        has_ev;
    logic [9:0]  ev;      // {ext, brk, code}
  } vec_t;

  vec_t vecs[12];

  ps2_scancode_decoder #(
    .FIFO_DEPTH    (Depth),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .app_clk     (app_clk),
    .app_arst_n  (app_arst_n),
    .byte_ena    (byte_ena),
    .byte_in     (byte_in),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_break   (key_break),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 app_clk = ~app_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Scoreboard side: on every handshake the head must match the oldest expectation.
  task automatic mon();
    logic [9:0] e;
    if (key_valid && key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h, required no event",
                 {key_ext, key_break, key_code});
      end else begin
        e = exp_q.pop_front();
        if ({key_ext, key_break, key_code} !== e) begin
          errors++;
          $display("FAIL event: got %h, required %h", {key_ext, key_break, key_code}, e);
        end
      end
    end
  endtask

  // One clock: sample on the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge app_clk);
    mon();
    @(posedge app_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    byte_ena = 1'b1;
    byte_in  = b;
    step();
    byte_ena = 1'b0;
  endtask

  task automatic drain(input string name);
    idle(Depth + 3);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    vecs[0]  = '{"make_1c",     1, 32'h0000001C, 1'b1, 10'h01C};
    vecs[1]  = '{"ext_brk_75",  3, 32'h0075F0E0, 1'b1, 10'h375};
    vecs[2]  = '{"brk_1c",      2, 32'h00001CF0, 1'b1, 10'h11C};
    vecs[3]  = '{"ext_75",      2, 32'h000075E0, 1'b1, 10'h275};
    vecs[4]  = '{"status_aa",   1, 32'h000000AA, 1'b0, 10'h000};
    vecs[5]  = '{"status_fa",   1, 32'h000000FA, 1'b0, 10'h000};
    vecs[6]  = '{"ext_ext_6b",  3, 32'h006BE0E0, 1'b1, 10'h26B};
    vecs[7]  = '{"brk_brk_29",  3, 32'h0029F0F0, 1'b1, 10'h129};
    vecs[8]  = '{"status_ee",   1, 32'h000000EE, 1'b0, 10'h000};
    vecs[9]  = '{"status_fe00", 2, 32'h000000FE, 1'b0, 10'h000};
    vecs[10] = '{"status_ff",   1, 32'h000000FF, 1'b0, 10'h000};
    vecs[11] = '{"eb_f0f0_5a",  4, 32'h5AF0F0E0, 1'b1, 10'h35A};

    app_arst_n   = 1'b0;
    byte_ena     = 1'b0;
    byte_in      = 8'h00;
    key_ready    = 1'b1;
    overflow_clr = 1'b0;
    #12;
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_ext_brk", {key_ext, key_break}, 0);
    check("rst_overflow", overflow, 0);
    @(negedge app_clk);
    app_arst_n = 1'b1;
    @(posedge app_clk);
    #1;

    // Latency: event visible right after the capturing edge.
    exp_q.push_back(10'h01C);
    send(8'h1C);
    check("latency_valid", key_valid, 1);
    drain("latency_drain");

    foreach (vecs[i]) begin
      if (vecs[i].has_ev) exp_q.push_back(vecs[i].ev);
      for (int k = 0; k < vecs[i].n; k++) send(vecs[i].bytes[8*k +: 8]);
      drain(vecs[i].name);
    end

    // Pause sequence, back to back, followed by a real key.
    exp_q.push_back(10'h01C);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    drain("pause_skip");

    // Prefix abandoned by timeout.
    exp_q.push_back(10'h01C);
    send(8'hE0);
    idle(To + 5);
    send(8'h1C);
    drain("timeout_ext");

    // Gap shorter than the timeout keeps the prefix.
    exp_q.push_back(10'h275);
    send(8'hE0);
    idle(To - 4);
    send(8'h75);
    drain("no_timeout_ext");

    // Overflow: fill with ready low, fifth make code dropped.
    key_ready = 1'b0;
    exp_q.push_back(10'h016);
    exp_q.push_back(10'h01E);
    exp_q.push_back(10'h026);
    exp_q.push_back(10'h025);
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    idle(2);
    check("ovf_set", overflow, 1);
    check("ovf_head", key_code, 8'h16);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    // Push with simultaneous pop at full.
    key_ready = 1'b1;
    exp_q.push_back(10'h02A);
    send(8'h2A);
    check("full_push_pop_ovf", overflow, 0);
    drain("full_push_pop_drain");

    // Reset in the middle of a break sequence with events queued.
    key_ready = 1'b0;
    send(8'h1C);
    send(8'h32);
    send(8'hF0);
    #2;
    app_arst_n = 1'b0;
    #1;
    check("midrst_valid", key_valid, 0);
    check("midrst_code", key_code, 0);
    idle(2);
    @(negedge app_clk);
    app_arst_n = 1'b1;
    @(posedge app_clk);
    #1;
    key_ready = 1'b1;
    exp_q.push_back(10'h01C);
    send(8'h1C);
    drain("after_rst_make");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
